ram_fifo_ctrl: RTL and testbench

//  Upstream sequencer for the 2x8 JK-flop RAM: turns push/pop handshakes into the RAM's

---
 rtl/ram_fifo_pkg.sv | 11 +
 rtl/ram_fifo_ptr.sv | 20 ++
 rtl/ram_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared state encoding and default widths for the RAM-backed FIFO sequencer.
package ram_fifo_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;
endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrap-around RAM address pointer with synchronous clear and increment.
// Latency: new value visible the cycle after inc. No backpressure.
// Wraps modulo 2**ADDR_W by natural overflow.
module ram_fifo_ptr #(
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (clear)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + PTR_ONE;
    end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Sequencer turning push/pop handshakes into RAM strobes, making the RAM a circular FIFO.
// Latency: write lands 1 cycle after accept; pop_valid pulses 2 cycles after accept.
// Backpressure: ready only in IDLE; pop wins ties. FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_r_w,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
`ifdef FIFO_ERR_FLAGS_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic              ram_clear
);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_acc;
    logic              pop_acc;

    assign ram_clear = clear;
    assign push_acc  = push_valid & push_ready;
    assign pop_acc   = pop_req & pop_ready;
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);

    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .clear (clear),
        .inc   (state == ST_WRITE),
        .ptr   (wr_ptr)
    );

    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .clear (clear),
        .inc   (state == ST_READ),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (clear)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pop_acc)
                    state_nxt = ST_READ;
                else if (push_acc)
                    state_nxt = ST_WRITE;
            end
            ST_WRITE: state_nxt = ST_IDLE;
            ST_READ:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A pending pop blocks the push so the two never share one RAM slot.
    always_comb begin
        push_ready = (state == ST_IDLE) & ~full & ~(pop_req & ~empty);
        pop_ready  = (state == ST_IDLE) & ~empty;
        ram_r_w    = (state == ST_WRITE);
        ram_addr   = (state == ST_WRITE) ? wr_ptr : rd_ptr;
        ram_in     = (state == ST_WRITE) ? wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (clear)
            wdata <= '0;
        else if (push_acc)
            wdata <= push_data;
    end

    // Count moves only when the RAM access completes, so an aborted op leaves it untouched.
    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (state == ST_WRITE)
            count <= count + CNT_ONE;
        else if (state == ST_READ)
            count <= count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= (state == ST_READ);
            if (state == ST_READ)
                pop_data <= ram_out;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (push_valid & full)
                overflow <= 1'b1;
            if (pop_req & empty)
                underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized bench for ram_fifo_ctrl against a queue-based FIFO model and a ram2x8 behavioural RAM.
module tb_ram_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 1;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              clear = 1'b1;
    logic              push_valid = 1'b0;
    logic [DATA_W-1:0] push_data = '0;
    logic              push_ready;
    logic              pop_req = 1'b0;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_r_w;
    logic [DATA_W-1:0] ram_in;
    logic [DATA_W-1:0] ram_out;
    logic              ram_clear;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .clear      (clear),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_req    (pop_req),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ram_addr   (ram_addr),
        .ram_r_w    (ram_r_w),
        .ram_in     (ram_in),
        .ram_out    (ram_out),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow   (overflow),
        .underflow  (underflow),
`endif
        .ram_clear  (ram_clear)
    );

    always #5 clk = ~clk;

    // ram2x8 stand-in: clear zeroes, write on edge when r_w=1, combinational read.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    assign ram_out = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (ram_r_w) begin
            mem[ram_addr] <= ram_in;
        end
    end

    int total = 0;
    int bad = 0;

    // Model: stored words, the op in flight, and where writes/reads land.
    logic [DATA_W-1:0] mq[$];
    int                m_mode = 0;      // 0 none, 1 write in flight, 2 read in flight
    logic [DATA_W-1:0] m_wd = '0;
    int                m_wa = 0;
    int                m_ra = 0;
    logic              m_pv = 1'b0;
    logic [DATA_W-1:0] m_pd = '0;
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;
    bit                armed = 1'b0;

    // Values seen in the most recent step, for hand-written expectations.
    int s_pushr, s_popr, s_pv, s_pd, s_full, s_empty, s_cnt, s_rw, s_addr, s_in;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit pv, input logic [DATA_W-1:0] pd, input bit pr, input bit clr);
        int  sz;
        bit  idle;
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_req    = pr;
        clear      = clr;
        #1;
        s_pushr = int'(push_ready); s_popr = int'(pop_ready);
        s_pv = int'(pop_valid); s_pd = int'(pop_data);
        s_full = int'(full); s_empty = int'(empty); s_cnt = int'(count);
        s_rw = int'(ram_r_w); s_addr = int'(ram_addr); s_in = int'(ram_in);
        sz   = mq.size();
        idle = (m_mode == 0);
        chk("ram_clear", int'(ram_clear), int'(clr));
        if (armed) begin
            chk("push_ready", s_pushr, int'(idle && sz < DEPTH && !(pr && sz > 0)));
            chk("pop_ready", s_popr, int'(idle && sz > 0));
            chk("count", s_cnt, sz);
            chk("full", s_full, int'(sz == DEPTH));
            chk("empty", s_empty, int'(sz == 0));
            chk("pop_valid", s_pv, int'(m_pv));
            chk("pop_data", s_pd, int'(m_pd));
            chk("ram_r_w", s_rw, int'(m_mode == 1));
            chk("ram_addr", s_addr, (m_mode == 1) ? m_wa : m_ra);
            if (m_mode == 1) chk("ram_in", s_in, int'(m_wd));
`ifdef FIFO_ERR_FLAGS_EN
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
`endif
        end
        @(posedge clk);
        if (clr) begin
            mq.delete();
            m_mode = 0; m_wa = 0; m_ra = 0;
            m_pv = 1'b0; m_pd = '0; m_ovf = 1'b0; m_unf = 1'b0;
            armed = 1'b1;
        end else begin
            m_pv = 1'b0;
            if (m_mode == 1) begin
                mq.push_back(m_wd);
                m_wa = (m_wa + 1) % DEPTH;
                m_mode = 0;
            end else if (m_mode == 2) begin
                m_pd = mq.pop_front();
                m_pv = 1'b1;
                m_ra = (m_ra + 1) % DEPTH;
                m_mode = 0;
            end else begin
                if (pv && sz == DEPTH) m_ovf = 1'b1;
                if (pr && sz == 0) m_unf = 1'b1;
                if (pr && sz > 0) m_mode = 2;
                else if (pv && sz < DEPTH) begin
                    m_mode = 1;
                    m_wd = pd;
                end
            end
        end
    endtask

    initial begin
        // 1: reset
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0);
        chk("rst_empty", s_empty, 1); chk("rst_full", s_full, 0); chk("rst_count", s_cnt, 0);
        chk("rst_rw", s_rw, 0); chk("rst_pv", s_pv, 0);

        // 2: two pushes fill the FIFO
        step(1, 8'h03, 0, 0); chk("p1_ready", s_pushr, 1);
        step(0, 8'h00, 0, 0); chk("w1_rw", s_rw, 1); chk("w1_addr", s_addr, 0); chk("w1_in", s_in, 3);
        step(1, 8'h09, 0, 0);
        step(0, 8'h00, 0, 0); chk("w2_rw", s_rw, 1); chk("w2_addr", s_addr, 1); chk("w2_in", s_in, 9);
        step(1, 8'h77, 0, 0); chk("full_cnt", s_cnt, 2); chk("full_flag", s_full, 1); chk("full_pushr", s_pushr, 0);
        step(0, 8'h00, 0, 0); chk("rejected_no_write", s_rw, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_set", int'(overflow), 1);
`endif

        // 3: drain in order
        step(0, 8'h00, 1, 0); chk("pop1_ready", s_popr, 1);
        step(0, 8'h00, 0, 0); chk("r1_pv", s_pv, 0);
        step(0, 8'h00, 1, 0); chk("r1_pv_n2", s_pv, 1); chk("r1_data", s_pd, 3);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0); chk("r2_pv", s_pv, 1); chk("r2_data", s_pd, 9); chk("drained", s_empty, 1);
        step(0, 8'h00, 0, 0); chk("pv_pulse", s_pv, 0);

        // 4: wrap-around
        step(1, 8'h04, 0, 0); step(0, 8'h00, 0, 0);
        step(1, 8'h0A, 0, 0); step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0); step(0, 8'h00, 0, 0);
        step(1, 8'h55, 0, 0); chk("wrap_d0", s_pd, 8'h04);
        step(0, 8'h00, 0, 0); chk("wrap_addr", s_addr, 0); chk("wrap_in", s_in, 8'h55);
        step(0, 8'h00, 1, 0); step(0, 8'h00, 0, 0);
        step(0, 8'h00, 1, 0); chk("wrap_d1", s_pd, 8'h0A);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 0); chk("wrap_d2", s_pd, 8'h55); chk("wrap_empty", s_empty, 1);

        // 5: simultaneous push and pop with one word stored
        step(1, 8'h11, 0, 0); step(0, 8'h00, 0, 0);
        step(1, 8'h22, 1, 0); chk("tie_pushr", s_pushr, 0); chk("tie_popr", s_popr, 1);
        step(1, 8'h22, 0, 0); chk("tie_read", s_rw, 0);
        step(1, 8'h22, 0, 0); chk("tie_data", s_pd, 8'h11); chk("tie_push_now", s_pushr, 1);
        step(0, 8'h00, 0, 0); chk("tie_write", s_rw, 1);
        step(0, 8'h00, 0, 0); chk("tie_count", s_cnt, 1);

        // 6: clear during WRITE aborts it
        step(0, 8'h00, 1, 0); step(0, 8'h00, 0, 0);
        step(1, 8'h33, 0, 0);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 0); chk("abort_cnt", s_cnt, 0); chk("abort_rw", s_rw, 0); chk("abort_pv", s_pv, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_cleared", int'(overflow), 0);
        step(0, 8'h00, 1, 0); step(0, 8'h00, 0, 0); chk("unf_set", int'(underflow), 1);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
